// File: rtl/spi_peripheral_tx.sv
// spi_peripheral_tx: SPI mode-0 peripheral transmitter driving CIPO from a valid/ready byte stream
// Ports: clk/rst_n system clock and async active-low reset; SCLK/spi_cs_n asynchronous controller
// inputs; CIPO/cipo_oe serial data and pad enable; tx_data/tx_valid/tx_ready byte handshake into a
// one-entry holding register; tx_done pulses per completed byte; tx_underrun pulses on idle-fill load.
module spi_peripheral_tx #(
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_FILL = '0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SCLK,
    input  logic                  spi_cs_n,
    output logic                  CIPO,
    output logic                  cipo_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_done,
    output logic                  tx_underrun
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t                state;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
    logic                  sclk_d, cs_d;
    logic [DATA_WIDTH-1:0] shift_reg, hold_reg;
    logic                  hold_valid, byte_seen;
    logic [CW-1:0]         bit_cnt;
    logic                  sclk_s, cs_s, sclk_rise, sclk_fall, cs_fall, accept, load_now;
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = cs_d & ~cs_s;
    assign tx_ready  = ~hold_valid;
    assign accept    = tx_valid & ~hold_valid;
    // A byte boundary reload only happens once a byte has completed in this frame;
    // the first byte of a frame is loaded by the LOAD state instead.
    assign load_now  = ~cs_s & ((state == LOAD) |
                       (state == SHIFT & sclk_fall & bit_cnt == '0 & byte_seen));
    assign CIPO      = cipo_oe & shift_reg[DATA_WIDTH-1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync   <= '0;
            cs_sync     <= '1;
            sclk_d      <= 1'b0;
            cs_d        <= 1'b1;
            state       <= IDLE;
            shift_reg   <= '0;
            hold_reg    <= '0;
            hold_valid  <= 1'b0;
            byte_seen   <= 1'b0;
            bit_cnt     <= '0;
            cipo_oe     <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_d      <= sclk_s;
            cs_d        <= cs_s;
            cipo_oe     <= ~cs_s;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            if (accept) begin
                hold_reg   <= tx_data;
                hold_valid <= 1'b1;
            end
            // Uses hold_valid from the start of the cycle; a same-cycle accept waits for the next boundary.
            if (load_now) begin
                if (hold_valid) begin
                    shift_reg  <= hold_reg;
                    hold_valid <= 1'b0;
                end else begin
                    shift_reg   <= IDLE_FILL;
                    tx_underrun <= 1'b1;
                end
            end
            if (cs_s) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                byte_seen <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= cs_fall ? LOAD : IDLE;
                        bit_cnt   <= '0;
                        byte_seen <= 1'b0;
                    end
                    LOAD: state <= SHIFT;
                    SHIFT: begin
                        if (sclk_rise) begin
                            if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                                bit_cnt   <= '0;
                                tx_done   <= 1'b1;
                                byte_seen <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else if (sclk_fall && bit_cnt != '0) begin
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
